mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Multi-cycle load/store unit sitting directly upstream of the 64×32 data memory `MEM`. `mem_access_unit` accepts byte-addressed load and store requests over a ready/done handshake and checks alignment. It converts byte and halfword stores into read-modify-write sequences and extracts and extends byte or halfword load data. It drives the memory's `WE`/`Addr`/`Data` pins and samples its asynchronous `SPO` output.

## Interface
- No parameters; geometry is fixed:
  - 8-bit byte address.
  - 64 words of 32 bits.
  - Little-endian byte lanes.
- `Clk` input 1: single clock; all state updates on the rising edge.
- `Rst` input 1: synchronous, active-high reset.
- `Req` input 1: request strobe; sampled only when `Ready`=1.
- `ReqWE` input 1: 1 = store, 0 = load.
- `ReqAddr` input 8: byte address.
- `ReqSize` input 2: 00 byte, 01 halfword, 10 word, 11 illegal.
- `ReqUnsigned` input 1: loads only; 1 = zero-extend, 0 = sign-extend.
- `ReqWData` input 32: store data, right-aligned (value in low bits).
- `Ready` output 1: unit idle, request will be accepted.
- `Done` output 1: one-cycle completion pulse.
- `Err` output 1: valid with `Done`; 1 = misaligned or illegal size, no memory access made.
- `RData` output 32: extended load result; valid with `Done` on loads and held until the next load completes.
- `MemWE` output 1: to `MEM.WE`.
- `MemAddr` output 6: to `MEM.Addr`; word index = `ReqAddr[7:2]`.
- `MemData` output 32: to `MEM.Data`.
- `MemSPO` input 32: from `MEM.SPO` (asynchronous read).

## Operation
- States: IDLE, READ, WRITE, DONE.
- Request capture in IDLE: a `Req` with `Ready`=1 registers address, size, unsigned flag, direction and write data.
- Transitions out of IDLE:
  - Error check first: `ReqSize`=11, halfword with `ReqAddr[0]`=1, or word with `ReqAddr[1:0]`≠0 → DONE with `Err`=1.
  - Load → READ.
  - Word store → WRITE.
  - Byte or halfword store → READ.
- READ: `MemAddr` = captured word index, `MemWE`=0; `MemSPO` is registered at the end of the cycle.
  - Load: next state DONE.
  - Store: next state WRITE.
- WRITE: `MemWE`=1 and `MemData` = merged word; next state DONE.
- Store merge:
  - Byte: lane `addr[1:0]` replaced by `WData[7:0]`; other lanes taken from the word read in READ.
  - Halfword: lanes `{addr[1],0}` and `{addr[1],1}` replaced by `WData[15:0]`.
  - Word: `MemData` = `WData`.
- Load extract:
  - Byte: `SPO >> (8*addr[1:0])`, low 8 bits.
  - Halfword: `SPO >> (16*addr[1])`, low 16 bits.
  - Either is sign- or zero-extended to 32 bits per `ReqUnsigned`; a word load returns `SPO` unchanged.
- DONE: `Done`=1 for exactly one cycle; next state IDLE.
- `Ready` = (state == IDLE); `Req` in any other state is ignored, not queued.
- `MemWE` = (state == WRITE) && !`Rst`.
  - A reset asserted during the WRITE cycle suppresses that write.
  - A reset in any other state aborts the access with no memory side effect.
- Reset values: state IDLE, `Ready`=1, `Done`=0, `Err`=0, `RData`=0, `MemWE`=0, `MemAddr`=0, `MemData`=0.
- Address wrap: none needed; the 8-bit byte address covers exactly 64 words.

## Timing
- Let E0 be the edge that samples `Req`.
- Load: READ in E0–E1, DONE in E1–E2; `RData` valid during E1–E2; latency 2 cycles.
- Word store: WRITE in E0–E1 (memory written at E1), DONE in E1–E2; latency 2 cycles.
- Sub-word store: READ in E0–E1, WRITE in E1–E2 (written at E2), DONE in E2–E3; latency 3 cycles.
- Error: DONE in E0–E1 with `Err`=1; latency 1 cycle; `MemWE` stays 0 and `RData` is unchanged.
- Back-to-back: `Ready` rises in the cycle after DONE, so peak throughput is one access per 3 cycles (word store or load).
- `MemAddr` and `MemData` are registered; the only combinational output paths are `MemWE`, `Ready` and `Done`, all decoded from state (and `Rst` for `MemWE`).

## Structure
- Package `mem_access_pkg`:
  - State enum (IDLE/READ/WRITE/DONE).
  - Size encodings `SZ_BYTE`/`SZ_HALF`/`SZ_WORD`.
  - Width constants (`BYTE_ADDR_W`=8, `WORD_ADDR_W`=6, `DATA_W`=32).
- Sub-module `byte_lane_align` (combinational): store merge and load extract/extend, instantiated once in `mem_access_unit`.
- The top level is FSM plus capture registers only.

## Test plan
- Word store 0xDEADBEEF @0x10, then word load @0x10 → `MEM` word 4 = 0xDEADBEEF; load `Done` at E0+2 with `RData`=0xDEADBEEF.
- Byte store 0xAA @0x11 over 0x11223344, then word load @0x10 → store `Done` at E0+3; word reads 0x1122AA44.
- Loads from word 0x8000F080 @0x20: signed byte @0x20 → 0xFFFFFF80; unsigned byte @0x20 → 0x00000080; signed half @0x22 → 0xFFFF8000.
- Halfword load @0x21 and word store @0x22 → `Done`+`Err` at E0+1; `MemWE` never asserted; `RData` and memory unchanged.
- `Req` held high for 6 cycles with load @0x00 → exactly two loads accepted, one per 3-cycle window; `Ready` low in READ/DONE.
- `Rst` asserted during the WRITE cycle of a byte store to word 0x3F → memory unchanged, next cycle IDLE, `Ready`=1, all outputs at reset values.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared types and constants for the load/store unit in front of the 64x32 data memory.
// Includes the size encodings, the FSM state type and the alignment check.
package mem_access_pkg;

    localparam int BYTE_ADDR_W = 8;
    localparam int WORD_ADDR_W = 6;
    localparam int DATA_W      = 32;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    // Size 11 is illegal; halfwords need bit 0 clear; words need bits 1:0 clear.
    function automatic logic access_error(input logic [1:0] size, input logic [1:0] addr_lo);
        logic err_v;
        case (size)
            SZ_BYTE: err_v = 1'b0;
            SZ_HALF: err_v = addr_lo[0];
            SZ_WORD: err_v = (addr_lo != 2'b00);
            default: err_v = 1'b1;
        endcase
        return err_v;
    endfunction

endpackage

// File: rtl/byte_lane_align.sv
// Little-endian lane steering: merges store data into the old word and
// extracts plus sign/zero-extends load data.
module byte_lane_align
    import mem_access_pkg::*;
(
    input  logic [1:0]        size,
    input  logic [1:0]        addr_lo,
    input  logic              is_unsigned,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] old_word,
    output logic [DATA_W-1:0] merged,
    output logic [DATA_W-1:0] extracted
);

    logic [4:0]        byte_sh_s;
    logic [4:0]        half_sh_s;
    logic [DATA_W-1:0] byte_src_s;
    logic [DATA_W-1:0] half_src_s;
    logic              sext_s;

    assign byte_sh_s  = {addr_lo, 3'b000};
    assign half_sh_s  = {addr_lo[1], 4'b0000};
    assign byte_src_s = old_word >> byte_sh_s;
    assign half_src_s = old_word >> half_sh_s;
    assign sext_s     = ~is_unsigned;

    // Store merge: clear the target lanes, then insert the right-aligned store data.
    always_comb begin
        merged = old_word;
        case (size)
            SZ_BYTE: merged = (old_word & ~(32'h0000_00FF << byte_sh_s))
                              | ({24'h00_0000, wdata[7:0]} << byte_sh_s);
            SZ_HALF: merged = (old_word & ~(32'h0000_FFFF << half_sh_s))
                              | ({16'h0000, wdata[15:0]} << half_sh_s);
            SZ_WORD: merged = wdata;
            default: merged = old_word;
        endcase
    end

    // Load extract and extend.
    always_comb begin
        extracted = old_word;
        case (size)
            SZ_BYTE: extracted = {{24{sext_s & byte_src_s[7]}}, byte_src_s[7:0]};
            SZ_HALF: extracted = {{16{sext_s & half_src_s[15]}}, half_src_s[15:0]};
            SZ_WORD: extracted = old_word;
            default: extracted = old_word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Multi-cycle load/store unit: request capture, alignment check, read-modify-write
// for sub-word stores, and extended load results for the 64x32 data memory.
module mem_access_unit
    import mem_access_pkg::*;
(
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic                   Req,
    input  logic                   ReqWE,
    input  logic [BYTE_ADDR_W-1:0] ReqAddr,
    input  logic [1:0]             ReqSize,
    input  logic                   ReqUnsigned,
    input  logic [DATA_W-1:0]      ReqWData,
    output logic                   Ready,
    output logic                   Done,
    output logic                   Err,
    output logic [DATA_W-1:0]      RData,
    output logic                   MemWE,
    output logic [WORD_ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0]      MemData,
    input  logic [DATA_W-1:0]      MemSPO
);

    state_t                 state_r;
    state_t                 state_next_s;
    logic                   we_r;
    logic [1:0]             size_r;
    logic [1:0]             addr_lo_r;
    logic                   unsigned_r;
    logic [DATA_W-1:0]      wdata_r;
    logic                   err_r;
    logic [DATA_W-1:0]      rdata_r;
    logic [WORD_ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0]      mem_data_r;
    logic                   accept_s;
    logic                   req_err_s;
    logic [DATA_W-1:0]      merged_s;
    logic [DATA_W-1:0]      extracted_s;

    assign accept_s  = Req & (state_r == ST_IDLE);
    assign req_err_s = access_error(ReqSize, ReqAddr[1:0]);

    byte_lane_align u_align (
        .size        (size_r),
        .addr_lo     (addr_lo_r),
        .is_unsigned (unsigned_r),
        .wdata       (wdata_r),
        .old_word    (MemSPO),
        .merged      (merged_s),
        .extracted   (extracted_s)
    );

    // State register.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode; errors short-circuit straight to DONE without touching memory.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!Req) begin
                    state_next_s = ST_IDLE;
                end else if (req_err_s) begin
                    state_next_s = ST_DONE;
                end else if (ReqWE && (ReqSize == SZ_WORD)) begin
                    state_next_s = ST_WRITE;
                end else begin
                    state_next_s = ST_READ;
                end
            end
            ST_READ:  state_next_s = we_r ? ST_WRITE : ST_DONE;
            ST_WRITE: state_next_s = ST_DONE;
            ST_DONE:  state_next_s = ST_IDLE;
            default:  state_next_s = ST_IDLE;
        endcase
    end

    // State-decoded outputs; reset gates the write strobe in the same cycle.
    always_comb begin
        Ready = 1'b0;
        Done  = 1'b0;
        MemWE = 1'b0;
        case (state_r)
            ST_IDLE:  Ready = 1'b1;
            ST_READ:  Ready = 1'b0;
            ST_WRITE: MemWE = ~Rst;
            ST_DONE:  Done  = 1'b1;
            default:  Ready = 1'b0;
        endcase
    end

    // Capture registers; the memory word read in READ is folded into MemData or RData.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            we_r       <= 1'b0;
            size_r     <= 2'b00;
            addr_lo_r  <= 2'b00;
            unsigned_r <= 1'b0;
            wdata_r    <= 32'h0000_0000;
            err_r      <= 1'b0;
            rdata_r    <= 32'h0000_0000;
            mem_addr_r <= 6'd0;
            mem_data_r <= 32'h0000_0000;
        end else if (accept_s) begin
            we_r       <= ReqWE;
            size_r     <= ReqSize;
            addr_lo_r  <= ReqAddr[1:0];
            unsigned_r <= ReqUnsigned;
            wdata_r    <= ReqWData;
            err_r      <= req_err_s;
            mem_addr_r <= ReqAddr[BYTE_ADDR_W-1:2];
            mem_data_r <= ReqWData;
        end else if (state_r == ST_READ) begin
            if (we_r) begin
                mem_data_r <= merged_s;
            end else begin
                rdata_r <= extracted_s;
            end
        end
    end

    assign Err     = err_r;
    assign RData   = rdata_r;
    assign MemAddr = mem_addr_r;
    assign MemData = mem_data_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench: table of requests against a behavioural 64x32 memory,
// with a scoreboard queue plus hand sequences for back-to-back and reset-in-WRITE.
module tb_mem_access_unit;

    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat;
        int          exp_writes;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        req_we;
    logic [7:0]  req_addr;
    logic [1:0]  req_size;
    logic        req_uns;
    logic [31:0] req_wdata;
    logic        ready;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic        mem_we;
    logic [5:0]  mem_addr;
    logic [31:0] mem_data;
    logic [31:0] mem_spo;

    logic [31:0] mem [64];
    int          wr_cnt = 0;
    int          n_cmp  = 0;
    int          n_fail = 0;
    vec_t        vecs[$];
    vec_t        sb[$];

    always #5 clk = ~clk;

    mem_access_unit dut (
        .Clk         (clk),
        .Rst         (rst),
        .Req         (req),
        .ReqWE       (req_we),
        .ReqAddr     (req_addr),
        .ReqSize     (req_size),
        .ReqUnsigned (req_uns),
        .ReqWData    (req_wdata),
        .Ready       (ready),
        .Done        (done),
        .Err         (err),
        .RData       (rdata),
        .MemWE       (mem_we),
        .MemAddr     (mem_addr),
        .MemData     (mem_data),
        .MemSPO      (mem_spo)
    );

    // Behavioural MEM: synchronous write, asynchronous read.
    assign mem_spo = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_we === 1'b1) begin
            mem[mem_addr] <= mem_data;
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic add(input logic we, input logic [7:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wdata, input logic e,
                       input logic [31:0] rd, input int lat, input int wr);
        vec_t v;
        v.we = we; v.addr = addr; v.size = size; v.uns = uns; v.wdata = wdata;
        v.exp_err = e; v.exp_rdata = rd; v.exp_lat = lat; v.exp_writes = wr;
        vecs.push_back(v);
    endtask

    // One request: drive in IDLE, measure latency to Done, then score it.
    task automatic run_vec(input vec_t v, input int idx);
        int   lat;
        int   wr0;
        vec_t e;
        @(negedge clk);
        chk($sformatf("v%0d ready", idx), {31'd0, ready}, 32'd1);
        req = 1'b1; req_we = v.we; req_addr = v.addr; req_size = v.size;
        req_uns = v.uns; req_wdata = v.wdata;
        sb.push_back(v);
        wr0 = wr_cnt;
        @(posedge clk);
        #1 req = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!done && lat < 8);
        e = sb.pop_front();
        if (!done) begin
            n_cmp++; n_fail++;
            $display("FAIL v%0d timeout: no Done after %0d cycles, expected %0d", idx, lat, e.exp_lat);
        end else begin
            chk($sformatf("v%0d latency", idx), lat, e.exp_lat);
            chk($sformatf("v%0d err", idx), {31'd0, err}, {31'd0, e.exp_err});
            if (!e.we || e.exp_err)
                chk($sformatf("v%0d rdata", idx), rdata, e.exp_rdata);
        end
        @(posedge clk);
        #1 chk($sformatf("v%0d writes", idx), wr_cnt - wr0, e.exp_writes);
    endtask

    initial begin
        logic [5:0] ready_pat;
        int         done_cnt;
        int         wr0;

        rst = 1'b1; req = 1'b0; req_we = 1'b0; req_addr = 8'h00; req_size = 2'b00;
        req_uns = 1'b0; req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst ready", {31'd0, ready}, 32'd1);
        chk("rst done", {31'd0, done}, 32'd0);
        chk("rst err", {31'd0, err}, 32'd0);
        chk("rst rdata", rdata, 32'h0);
        chk("rst memwe", {31'd0, mem_we}, 32'd0);
        chk("rst memaddr", {26'd0, mem_addr}, 32'd0);
        chk("rst memdata", mem_data, 32'h0);
        rst = 1'b0;

        //  we    addr   size   uns   wdata          err   rdata          lat wr
        add(1'b1, 8'h10, 2'b10, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0,        2, 1);
        add(1'b0, 8'h10, 2'b10, 1'b0, 32'h0,        1'b0, 32'hDEADBEEF, 2, 0);
        add(1'b1, 8'h10, 2'b10, 1'b0, 32'h11223344, 1'b0, 32'h0,        2, 1);
        add(1'b1, 8'h11, 2'b00, 1'b0, 32'h000000AA, 1'b0, 32'h0,        3, 1);
        add(1'b0, 8'h10, 2'b10, 1'b0, 32'h0,        1'b0, 32'h1122AA44, 2, 0);
        add(1'b1, 8'h20, 2'b10, 1'b0, 32'h8000F080, 1'b0, 32'h0,        2, 1);
        add(1'b0, 8'h20, 2'b00, 1'b0, 32'h0,        1'b0, 32'hFFFFFF80, 2, 0);
        add(1'b0, 8'h20, 2'b00, 1'b1, 32'h0,        1'b0, 32'h00000080, 2, 0);
        add(1'b0, 8'h22, 2'b01, 1'b0, 32'h0,        1'b0, 32'hFFFF8000, 2, 0);
        add(1'b0, 8'h22, 2'b01, 1'b1, 32'h0,        1'b0, 32'h00008000, 2, 0);
        add(1'b0, 8'h21, 2'b00, 1'b0, 32'h0,        1'b0, 32'hFFFFFFF0, 2, 0);
        add(1'b0, 8'h20, 2'b01, 1'b0, 32'h0,        1'b0, 32'hFFFFF080, 2, 0);
        add(1'b1, 8'h22, 2'b01, 1'b0, 32'hFFFF1234, 1'b0, 32'h0,        3, 1);
        add(1'b1, 8'h23, 2'b00, 1'b0, 32'hFFFFFF5A, 1'b0, 32'h0,        3, 1);
        add(1'b0, 8'h20, 2'b10, 1'b0, 32'h0,        1'b0, 32'h5A34F080, 2, 0);
        add(1'b0, 8'h23, 2'b00, 1'b1, 32'h0,        1'b0, 32'h0000005A, 2, 0);
        add(1'b0, 8'h21, 2'b01, 1'b0, 32'h0,        1'b1, 32'h0000005A, 1, 0);
        add(1'b1, 8'h22, 2'b10, 1'b0, 32'h12345678, 1'b1, 32'h0000005A, 1, 0);
        add(1'b0, 8'h00, 2'b11, 1'b0, 32'h0,        1'b1, 32'h0000005A, 1, 0);
        add(1'b1, 8'h13, 2'b01, 1'b0, 32'h0000BBBB, 1'b1, 32'h0000005A, 1, 0);
        add(1'b1, 8'h00, 2'b10, 1'b0, 32'hCAFE0001, 1'b0, 32'h0,        2, 1);
        add(1'b1, 8'hFC, 2'b10, 1'b0, 32'h01020304, 1'b0, 32'h0,        2, 1);
        add(1'b0, 8'hFE, 2'b00, 1'b0, 32'h0,        1'b0, 32'h00000002, 2, 0);

        foreach (vecs[i]) run_vec(vecs[i], i);
        chk("mem word4", mem[4], 32'h1122AA44);
        chk("mem word8", mem[8], 32'h5A34F080);
        chk("sb empty", sb.size(), 0);

        // Req held for 6 edges: accepts at E0 and E3 only.
        @(negedge clk);
        req = 1'b1; req_we = 1'b0; req_addr = 8'h00; req_size = 2'b10; req_uns = 1'b0;
        done_cnt = 0; ready_pat = 6'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1 if (i == 5) req = 1'b0;
            @(negedge clk);
            ready_pat = {ready_pat[4:0], ready};
            if (done) done_cnt++;
        end
        repeat (3) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        chk("b2b ready pattern", {26'd0, ready_pat}, 32'h0000_0009);
        chk("b2b done count", done_cnt, 2);
        chk("b2b rdata", rdata, 32'hCAFE0001);

        // Reset during WRITE of a byte store to word 0x3F: write suppressed.
        @(negedge clk);
        req = 1'b1; req_we = 1'b1; req_addr = 8'hFD; req_size = 2'b00; req_wdata = 32'h00000077;
        wr0 = wr_cnt;
        @(posedge clk);
        #1 req = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rstw memwe gated", {31'd0, mem_we}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rstw ready", {31'd0, ready}, 32'd1);
        chk("rstw done", {31'd0, done}, 32'd0);
        chk("rstw err", {31'd0, err}, 32'd0);
        chk("rstw rdata", rdata, 32'h0);
        chk("rstw memwe", {31'd0, mem_we}, 32'd0);
        chk("rstw memaddr", {26'd0, mem_addr}, 32'd0);
        chk("rstw memdata", mem_data, 32'h0);
        chk("rstw writes", wr_cnt - wr0, 0);
        chk("rstw mem word63", mem[63], 32'h01020304);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
